axi4_lite_slave_regs: RTL
=========================

# axi4_lite_slave_regs

AXI4-Lite responder with a parametrized bank of read/write registers, the subordinate end of the AXI4-Lite VIP interface. It accepts write address/data, returns write responses, and serves reads on independent write and read paths. It is the DUT-side counterpart the VIP master agent drives, and a reusable register block for small peripherals.

## Interface
- P_DATA_WIDTH, 32, data bus width in bits; must be 32 or 64.
- P_ADDR_WIDTH, 8, address bus width in bits.
- P_NUM_REGS, 16, number of registers; must be ≤ 2^(P_ADDR_WIDTH − log2(P_DATA_WIDTH/8)).
- clk  in  1  single clock; all logic on the rising edge.
- arst_n  in  1  reset, asynchronous assert, active-low.
- awvalid in 1, awready out 1, awaddr in P_ADDR_WIDTH, awprot in 3: write address channel.
- wvalid in 1, wready out 1, wdata in P_DATA_WIDTH, wstrb in P_DATA_WIDTH/8: write data channel.
- bvalid out 1, bready in 1, bresp out 2: write response channel.
- arvalid in 1, arready out 1, araddr in P_ADDR_WIDTH, arprot in 3: read address channel.
- rvalid out 1, rready in 1, rdata out P_DATA_WIDTH, rresp out 2: read data channel.

## Operation
- Index = addr[P_ADDR_WIDTH-1 : log2(P_DATA_WIDTH/8)]; low byte-offset bits are ignored.
- Index ≥ P_NUM_REGS: DECERR (2'b11). Write is discarded; rdata = 0. Otherwise OKAY (2'b00).
- Write FSM states:
  - WR_IDLE: awready=wready=1.
    - AW and W handshake in the same cycle → WR_RESP.
    - AW only → WR_HAVE_A (address latched).
    - W only → WR_HAVE_D (data and strobe latched).
  - WR_HAVE_A: awready=0, wready=1; W handshake → WR_RESP.
  - WR_HAVE_D: awready=1, wready=0; AW handshake → WR_RESP.
  - WR_RESP: awready=wready=0, bvalid=1, bresp held stable; bready → WR_IDLE.
- Register update happens on the edge entering WR_RESP. Byte lane i is written only where wstrb[i]=1. wstrb=0 writes nothing and still responds OKAY.
- Read FSM states:
  - RD_IDLE: arready=1; AR handshake → RD_RESP, with rdata/rresp captured on that edge.
  - RD_RESP: arready=0, rvalid=1; rdata/rresp held stable until rready; rready → RD_IDLE.
- Read and write paths are fully independent and may be active in the same cycle. A read captured on the same edge as a write commit to the same register returns the old value.
- awprot/arprot are ignored unless the configuration macro below is defined.
- Reset mid-transaction: all in-flight state is dropped, FSMs return to idle, and no response is issued for the aborted transaction.

## Timing
- All outputs are registered.
- Reset values:
  - awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=2'b00, rdata=0, all registers 0.
  - Ready outputs rise on the first rising clk edge after arst_n deasserts.
- Write latency: bvalid rises 1 cycle after the later of the AW/W handshakes.
- Read latency: rvalid rises 1 cycle after the AR handshake.
- Peak throughput: one write per 2 cycles and one read per 2 cycles, with bready/rready held high.
- Ready never depends combinationally on valid. Once asserted, bvalid/rvalid hold until the handshake.

## Configuration
- AXI4_LITE_SLAVE_PROT_CHECK_EN defined:
  - A write with awprot[0]=0 (unprivileged) to an in-range register returns SLVERR (2'b10) and is discarded.
  - A read with arprot[0]=0 to an in-range register returns SLVERR with rdata=0.
  - DECERR takes precedence over SLVERR.
- Macro undefined: prot inputs are unused and never produce SLVERR.

## Test plan
- Reset then write awaddr=0x04, wdata=0xDEADBEEF, wstrb=4'hF, AW and W in the same cycle → bvalid the next cycle with bresp=00; read 0x04 → rdata=0xDEADBEEF, rresp=00.
- W presented 3 cycles before AW (wdata=0x11223344, addr 0x08), then a write to 0x08 with wstrb=4'b0010, wdata=0x0000AA00 → read 0x08 returns 0x1122AA44.
- Read awaddr 0x40 with P_NUM_REGS=16 → rresp=11, rdata=0; write to 0x40 → bresp=11; a read-back of every register still shows its prior value.
- bready held low for 5 cycles after bvalid → bvalid/bresp stable and awready/wready=0 throughout; bready=1 → back to idle with readies=1 the next cycle.
- Concurrent write 0x0C←0xCAFEF00D and read 0x0C captured on the commit edge → rdata=old value 0; a subsequent read returns 0xCAFEF00D.
- arst_n pulsed low while in WR_HAVE_A → no bvalid; all registers 0; readies reassert 1 cycle after release. With PROT_CHECK_EN: a write with awprot=3'b000 → bresp=10.

Source files
------------

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite subordinate with a bank of byte-strobed read/write registers and independent write/read paths.
// Optional AXI4_LITE_SLAVE_PROT_CHECK_EN: unprivileged (prot[0]=0) accesses to in-range registers get SLVERR.
module axi4_lite_slave_regs #(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_ADDR_WIDTH = 8,
    parameter int P_NUM_REGS   = 16
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [P_ADDR_WIDTH-1:0]   awaddr,
    input  logic [2:0]                awprot,
    input  logic                      wvalid,
    output logic                      wready,
    input  logic [P_DATA_WIDTH-1:0]   wdata,
    input  logic [P_DATA_WIDTH/8-1:0] wstrb,
    output logic                      bvalid,
    input  logic                      bready,
    output logic [1:0]                bresp,
    input  logic                      arvalid,
    output logic                      arready,
    input  logic [P_ADDR_WIDTH-1:0]   araddr,
    input  logic [2:0]                arprot,
    output logic                      rvalid,
    input  logic                      rready,
    output logic [P_DATA_WIDTH-1:0]   rdata,
    output logic [1:0]                rresp
);
    localparam int STRB_W = P_DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int IDX_W  = P_ADDR_WIDTH - OFFS;
    localparam logic [IDX_W:0] NUM_REGS_C = (IDX_W + 1)'(P_NUM_REGS);
    localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
    localparam logic [1:0] WR_IDLE = 2'd0, WR_HAVE_A = 2'd1, WR_HAVE_D = 2'd2, WR_RESP = 2'd3;
    localparam logic [0:0] RD_IDLE = 1'b0, RD_RESP = 1'b1;

    // Out-of-range decode outranks the privilege check.
    function automatic logic [1:0] resp_for(input logic [IDX_W-1:0] idx, input logic priv);
        logic [1:0] r;
        if ({1'b0, idx} >= NUM_REGS_C) r = RESP_DECERR;
        else if (!priv)                r = RESP_SLVERR;
        else                           r = RESP_OKAY;
        return r;
    endfunction

    logic [1:0]              wr_state_r, wr_nxt_s;
    logic                    awready_r, wready_r, bvalid_r;
    logic [1:0]              bresp_r, wr_resp_s;
    logic                    aw_hs_s, w_hs_s, commit_s;
    logic [IDX_W-1:0]        aw_idx_r, wr_idx_s;
    logic                    aw_priv_r, wr_priv_s, aw_priv_in_s, ar_priv_in_s;
    logic [P_DATA_WIDTH-1:0] wdata_r, wr_data_s;
    logic [STRB_W-1:0]       wstrb_r, wr_strb_s;
    logic [P_DATA_WIDTH-1:0] regs_r [P_NUM_REGS];
    logic [0:0]              rd_state_r, rd_nxt_s;
    logic                    arready_r, rvalid_r, ar_hs_s;
    logic [P_DATA_WIDTH-1:0] rdata_r, rd_word_s;
    logic [1:0]              rresp_r, rd_resp_s;
    logic [IDX_W-1:0]        rd_idx_s;
    logic                    unused_s;

`ifdef AXI4_LITE_SLAVE_PROT_CHECK_EN
    assign aw_priv_in_s = awprot[0];
    assign ar_priv_in_s = arprot[0];
    assign unused_s     = ^{awprot[2:1], arprot[2:1], awaddr[OFFS-1:0], araddr[OFFS-1:0]};
`else
    assign aw_priv_in_s = 1'b1;
    assign ar_priv_in_s = 1'b1;
    assign unused_s     = ^{awprot, arprot, awaddr[OFFS-1:0], araddr[OFFS-1:0]};
`endif

    // Write FSM next state; address/data come from the live bus when handshaking now, else from the latch.
    always_comb begin
        aw_hs_s  = awvalid & awready_r;
        w_hs_s   = wvalid & wready_r;
        wr_nxt_s = wr_state_r;
        case (wr_state_r)
            WR_IDLE: begin
                if (aw_hs_s && w_hs_s) wr_nxt_s = WR_RESP;
                else if (aw_hs_s)      wr_nxt_s = WR_HAVE_A;
                else if (w_hs_s)       wr_nxt_s = WR_HAVE_D;
                else                   wr_nxt_s = WR_IDLE;
            end
            WR_HAVE_A: wr_nxt_s = w_hs_s  ? WR_RESP : WR_HAVE_A;
            WR_HAVE_D: wr_nxt_s = aw_hs_s ? WR_RESP : WR_HAVE_D;
            WR_RESP:   wr_nxt_s = bready  ? WR_IDLE : WR_RESP;
            default:   wr_nxt_s = WR_IDLE;
        endcase
        commit_s  = (wr_nxt_s == WR_RESP) && (wr_state_r != WR_RESP);
        wr_idx_s  = aw_hs_s ? awaddr[P_ADDR_WIDTH-1:OFFS] : aw_idx_r;
        wr_priv_s = aw_hs_s ? aw_priv_in_s : aw_priv_r;
        wr_data_s = w_hs_s ? wdata : wdata_r;
        wr_strb_s = w_hs_s ? wstrb : wstrb_r;
        wr_resp_s = resp_for(wr_idx_s, wr_priv_s);
    end

    // Write control: readies and bvalid are registered from the next state.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_state_r <= WR_IDLE;
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
            aw_idx_r   <= {IDX_W{1'b0}};
            aw_priv_r  <= 1'b0;
            wdata_r    <= {P_DATA_WIDTH{1'b0}};
            wstrb_r    <= {STRB_W{1'b0}};
        end else begin
            wr_state_r <= wr_nxt_s;
            awready_r  <= (wr_nxt_s == WR_IDLE) || (wr_nxt_s == WR_HAVE_D);
            wready_r   <= (wr_nxt_s == WR_IDLE) || (wr_nxt_s == WR_HAVE_A);
            bvalid_r   <= (wr_nxt_s == WR_RESP);
            if (aw_hs_s) begin
                aw_idx_r  <= awaddr[P_ADDR_WIDTH-1:OFFS];
                aw_priv_r <= aw_priv_in_s;
            end
            if (w_hs_s) begin
                wdata_r <= wdata;
                wstrb_r <= wstrb;
            end
            if (commit_s) bresp_r <= wr_resp_s;
        end
    end

    // Register bank: byte-lane update on the edge entering the response state.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < P_NUM_REGS; i++) regs_r[i] <= {P_DATA_WIDTH{1'b0}};
        end else begin
            for (int i = 0; i < P_NUM_REGS; i++)
                for (int b = 0; b < STRB_W; b++)
                    if (commit_s && (wr_resp_s == RESP_OKAY) && (wr_idx_s == IDX_W'(i)) && wr_strb_s[b])
                        regs_r[i][b*8 +: 8] <= wr_data_s[b*8 +: 8];
        end
    end

    // Read FSM next state and read-side decode.
    always_comb begin
        ar_hs_s   = arvalid & arready_r;
        rd_idx_s  = araddr[P_ADDR_WIDTH-1:OFFS];
        rd_resp_s = resp_for(rd_idx_s, ar_priv_in_s);
        rd_word_s = {P_DATA_WIDTH{1'b0}};
        for (int i = 0; i < P_NUM_REGS; i++)
            rd_word_s = (rd_idx_s == IDX_W'(i)) ? regs_r[i] : rd_word_s;
        case (rd_state_r)
            RD_IDLE: rd_nxt_s = ar_hs_s ? RD_RESP : RD_IDLE;
            RD_RESP: rd_nxt_s = rready  ? RD_IDLE : RD_RESP;
            default: rd_nxt_s = RD_IDLE;
        endcase
    end

    // Read control; data/response captured on the AR handshake edge and held until the next one.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_state_r <= RD_IDLE;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
            rdata_r    <= {P_DATA_WIDTH{1'b0}};
            rresp_r    <= RESP_OKAY;
        end else begin
            rd_state_r <= rd_nxt_s;
            arready_r  <= (rd_nxt_s == RD_IDLE);
            rvalid_r   <= (rd_nxt_s == RD_RESP);
            if (ar_hs_s) begin
                rdata_r <= (rd_resp_s == RESP_OKAY) ? rd_word_s : {P_DATA_WIDTH{1'b0}};
                rresp_r <= rd_resp_s;
            end
        end
    end

    assign awready = awready_r;
    assign wready  = wready_r;
    assign bvalid  = bvalid_r;
    assign bresp   = bresp_r;
    assign arready = arready_r;
    assign rvalid  = rvalid_r;
    assign rdata   = rdata_r;
    assign rresp   = rresp_r;
endmodule
